stream_dist_1to4: RTL and testbench

Four-way stream distributor, the user-side producer for a leaf with one input and four output ports. It consumes the 32-bit word stream the leaf interface delivers on its single user output port. It deals those words in fixed-size blocks, round-robin, onto four output streams that drive the interface's four user input ports. All ports use the codebase's ap_vld/ap_ack handshake, and each output has a small elastic buffer.

---
 rtl/dist_pkg.sv | 22 ++
 rtl/stream_fifo.sv | 58 +++++
 rtl/stream_dist_1to4.sv | 130 +++++++++++++
 tb/tb_stream_dist_1to4.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dist_pkg.sv
// dist_pkg: shared constants and types for the stream distributor.
//   PAYLOAD_BITS / NUM_OUT : default word width and output count
//   payload_t              : one stream word
//   ptr_t                  : output select pointer
//   stat_t                 : statistics counter
//   sat_inc()              : saturating +1 for stat_t
package dist_pkg;

  localparam int unsigned PAYLOAD_BITS = 32;
  localparam int unsigned NUM_OUT      = 4;
  localparam int unsigned STAT_BITS    = 32;

  typedef logic [PAYLOAD_BITS-1:0]    payload_t;
  typedef logic [$clog2(NUM_OUT)-1:0] ptr_t;
  typedef logic [STAT_BITS-1:0]       stat_t;

  // Counters stick at all-ones instead of wrapping.
  function automatic stat_t sat_inc(stat_t v);
    return (&v) ? v : v + stat_t'(1);
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// stream_fifo: small synchronous FIFO used as the per-output elastic buffer.
//   clk, rst_n      : clock, asynchronous active-low reset
//   push, push_data : write request and word (ignored when full)
//   pop             : read request (ignored when empty)
//   full, empty     : occupancy flags
//   head            : oldest stored word, valid while empty is 0
module stream_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_idx_q, rd_idx_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Indices wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_idx_q <= wr_idx_q + 1'b1;
      if (do_pop)  rd_idx_q <= rd_idx_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: contents are only visible while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx_q] <= push_data;
  end

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  assign head  = mem[rd_idx_q];

endmodule

// File: rtl/stream_dist_1to4.sv
// stream_dist_1to4: deals an ap_vld/ap_ack word stream in blocks of BLOCK_LEN words,
// round-robin, onto four buffered output streams.
//   clk_user, reset            : clock, asynchronous active-low reset
//   ap_start / ap_idle         : intake enable / all buffers empty and no intake
//   Input_1_V_V*               : input stream (data, vld, ack)
//   Output_k_V_V*, k=1..4      : output streams (data, vld, ack)
//   stat_words_k, stat_stall   : statistics, built only when DIST_STATS_EN is defined,
//                                otherwise tied to zero
module stream_dist_1to4 #(
  parameter int unsigned PAYLOAD_BITS = 32,
  parameter int unsigned NUM_OUT      = 4,
  parameter int unsigned BLOCK_LEN    = 1,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic                    clk_user,
  input  logic                    reset,
  input  logic                    ap_start,
  output logic                    ap_idle,
  input  logic [PAYLOAD_BITS-1:0] Input_1_V_V,
  input  logic                    Input_1_V_V_ap_vld,
  output logic                    Input_1_V_V_ap_ack,
  output logic [PAYLOAD_BITS-1:0] Output_1_V_V,
  output logic                    Output_1_V_V_ap_vld,
  input  logic                    Output_1_V_V_ap_ack,
  output logic [PAYLOAD_BITS-1:0] Output_2_V_V,
  output logic                    Output_2_V_V_ap_vld,
  input  logic                    Output_2_V_V_ap_ack,
  output logic [PAYLOAD_BITS-1:0] Output_3_V_V,
  output logic                    Output_3_V_V_ap_vld,
  input  logic                    Output_3_V_V_ap_ack,
  output logic [PAYLOAD_BITS-1:0] Output_4_V_V,
  output logic                    Output_4_V_V_ap_vld,
  input  logic                    Output_4_V_V_ap_ack,
  output logic [31:0]             stat_words_1,
  output logic [31:0]             stat_words_2,
  output logic [31:0]             stat_words_3,
  output logic [31:0]             stat_words_4,
  output logic [31:0]             stat_stall
);

  import dist_pkg::*;

  logic [NUM_OUT-1:0]      full, empty, push, out_ack;
  logic [PAYLOAD_BITS-1:0] head [NUM_OUT];
  ptr_t                    ptr_q;
  logic [7:0]              blk_cnt_q;
  logic                    in_ack, in_xfer;

  // Reset term keeps ack low while reset is held, even with ap_start high.
  assign in_ack             = reset & ap_start & ~full[ptr_q];
  assign in_xfer            = Input_1_V_V_ap_vld & in_ack;
  assign Input_1_V_V_ap_ack = in_ack;
  assign ap_idle            = (&empty) & ~in_xfer;

  assign out_ack = {Output_4_V_V_ap_ack, Output_3_V_V_ap_ack,
                    Output_2_V_V_ap_ack, Output_1_V_V_ap_ack};

  // Pointer and block counter only move on an input transfer, so a stalled or
  // gated block resumes on the same output.
  always_ff @(posedge clk_user or negedge reset) begin
    if (!reset) begin
      ptr_q     <= '0;
      blk_cnt_q <= '0;
    end else if (in_xfer) begin
      if (blk_cnt_q == 8'(BLOCK_LEN - 1)) begin
        blk_cnt_q <= '0;
        ptr_q     <= (ptr_q == ptr_t'(NUM_OUT - 1)) ? '0 : ptr_q + 1'b1;
      end else begin
        blk_cnt_q <= blk_cnt_q + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_buf
    assign push[k] = in_xfer & (ptr_q == ptr_t'(k));

    stream_fifo #(
      .WIDTH (PAYLOAD_BITS),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk_user),
      .rst_n     (reset),
      .push      (push[k]),
      .push_data (Input_1_V_V),
      .pop       (out_ack[k]),
      .full      (full[k]),
      .empty     (empty[k]),
      .head      (head[k])
    );
  end

  assign Output_1_V_V        = head[0];
  assign Output_2_V_V        = head[1];
  assign Output_3_V_V        = head[2];
  assign Output_4_V_V        = head[3];
  assign Output_1_V_V_ap_vld = ~empty[0];
  assign Output_2_V_V_ap_vld = ~empty[1];
  assign Output_3_V_V_ap_vld = ~empty[2];
  assign Output_4_V_V_ap_vld = ~empty[3];

`ifdef DIST_STATS_EN
  stat_t words_q [NUM_OUT];
  stat_t stall_q;

  always_ff @(posedge clk_user or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_OUT; k++) words_q[k] <= '0;
      stall_q <= '0;
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (~empty[k] & out_ack[k]) words_q[k] <= sat_inc(words_q[k]);
      end
      if (Input_1_V_V_ap_vld & ~in_ack) stall_q <= sat_inc(stall_q);
    end
  end

  assign stat_words_1 = words_q[0];
  assign stat_words_2 = words_q[1];
  assign stat_words_3 = words_q[2];
  assign stat_words_4 = words_q[3];
  assign stat_stall   = stall_q;
`else
  assign stat_words_1 = stat_t'(0);
  assign stat_words_2 = stat_t'(0);
  assign stat_words_3 = stat_t'(0);
  assign stat_words_4 = stat_t'(0);
  assign stat_stall   = stat_t'(0);
`endif

endmodule

// File: tb/tb_stream_dist_1to4.sv
// Bench: two distributors (BLOCK_LEN 1 and 3) share one stimulus stream and are
// checked every cycle against a queue-based model of the dealing rule.
module tb_stream_dist_1to4;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        in_vld = 1'b0;
  logic [31:0] din = '0;
  logic [3:0]  oack = '0;

  logic        got_ack  [2];
  logic        got_idle [2];
  logic        got_vld  [2][4];
  logic [31:0] got_dat  [2][4];
  logic [31:0] got_sw   [2][4];
  logic [31:0] got_stall[2];

  always #5 clk = ~clk;

  stream_dist_1to4 #(.BLOCK_LEN(1), .FIFO_DEPTH(DEPTH)) u_dut_bl1 (
    .clk_user(clk), .reset(reset), .ap_start(start), .ap_idle(got_idle[0]),
    .Input_1_V_V(din), .Input_1_V_V_ap_vld(in_vld), .Input_1_V_V_ap_ack(got_ack[0]),
    .Output_1_V_V(got_dat[0][0]), .Output_1_V_V_ap_vld(got_vld[0][0]),
    .Output_1_V_V_ap_ack(oack[0]),
    .Output_2_V_V(got_dat[0][1]), .Output_2_V_V_ap_vld(got_vld[0][1]),
    .Output_2_V_V_ap_ack(oack[1]),
    .Output_3_V_V(got_dat[0][2]), .Output_3_V_V_ap_vld(got_vld[0][2]),
    .Output_3_V_V_ap_ack(oack[2]),
    .Output_4_V_V(got_dat[0][3]), .Output_4_V_V_ap_vld(got_vld[0][3]),
    .Output_4_V_V_ap_ack(oack[3]),
    .stat_words_1(got_sw[0][0]), .stat_words_2(got_sw[0][1]),
    .stat_words_3(got_sw[0][2]), .stat_words_4(got_sw[0][3]), .stat_stall(got_stall[0])
  );

  stream_dist_1to4 #(.BLOCK_LEN(3), .FIFO_DEPTH(DEPTH)) u_dut_bl3 (
    .clk_user(clk), .reset(reset), .ap_start(start), .ap_idle(got_idle[1]),
    .Input_1_V_V(din), .Input_1_V_V_ap_vld(in_vld), .Input_1_V_V_ap_ack(got_ack[1]),
    .Output_1_V_V(got_dat[1][0]), .Output_1_V_V_ap_vld(got_vld[1][0]),
    .Output_1_V_V_ap_ack(oack[0]),
    .Output_2_V_V(got_dat[1][1]), .Output_2_V_V_ap_vld(got_vld[1][1]),
    .Output_2_V_V_ap_ack(oack[1]),
    .Output_3_V_V(got_dat[1][2]), .Output_3_V_V_ap_vld(got_vld[1][2]),
    .Output_3_V_V_ap_ack(oack[2]),
    .Output_4_V_V(got_dat[1][3]), .Output_4_V_V_ap_vld(got_vld[1][3]),
    .Output_4_V_V_ap_ack(oack[3]),
    .stat_words_1(got_sw[1][0]), .stat_words_2(got_sw[1][1]),
    .stat_words_3(got_sw[1][2]), .stat_words_4(got_sw[1][3]), .stat_stall(got_stall[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: the n-th accepted word since reset goes to output (n / BLOCK_LEN) % 4.
  int          bl [2] = '{1, 3};
  logic [31:0] mq [8][$];
  int          acc [2];
  int          words_m [2][4];
  int          stall_m [2];
  bit          acc_now [2];

  task automatic model_cycle(int d);
    int    qi;
    bit    exp_ack, all_empty, nonempty;
    bit    pop_k [4];
    string pfx;
    logic [31:0] exp_stat;
    pfx = $sformatf("bl%0d", bl[d]);
    if (!reset) begin
      for (int k = 0; k < 4; k++) begin
        mq[d*4+k].delete();
        words_m[d][k] = 0;
      end
      acc[d] = 0;
      stall_m[d] = 0;
    end
    qi = d*4 + (acc[d] / bl[d]) % 4;
    exp_ack = reset && start && (mq[qi].size() < DEPTH);
    check_eq({pfx, "_in_ack"}, 32'(got_ack[d]), 32'(exp_ack));
    all_empty = 1'b1;
    for (int k = 0; k < 4; k++) begin
      nonempty = mq[d*4+k].size() > 0;
      if (nonempty) all_empty = 1'b0;
      check_eq($sformatf("%s_vld%0d", pfx, k+1), 32'(got_vld[d][k]), 32'(nonempty));
      if (nonempty) check_eq($sformatf("%s_data%0d", pfx, k+1), got_dat[d][k], mq[d*4+k][0]);
      pop_k[k] = nonempty && oack[k];
    end
    check_eq({pfx, "_idle"}, 32'(got_idle[d]), 32'(all_empty && !(in_vld && exp_ack)));
    for (int k = 0; k < 4; k++) begin
`ifdef DIST_STATS_EN
      exp_stat = 32'(words_m[d][k]);
`else
      exp_stat = '0;
`endif
      check_eq($sformatf("%s_stat_words%0d", pfx, k+1), got_sw[d][k], exp_stat);
    end
`ifdef DIST_STATS_EN
    exp_stat = 32'(stall_m[d]);
`else
    exp_stat = '0;
`endif
    check_eq({pfx, "_stat_stall"}, got_stall[d], exp_stat);
    acc_now[d] = 1'b0;
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        if (pop_k[k]) begin
          void'(mq[d*4+k].pop_front());
          words_m[d][k]++;
        end
      end
      if (in_vld && exp_ack) begin
        mq[qi].push_back(din);
        acc[d]++;
        acc_now[d] = 1'b1;
      end
      if (in_vld && !exp_ack) stall_m[d]++;
    end
  endtask

  // Compare mid-cycle, then advance to just after the next rising edge.
  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) model_cycle(d);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_vld = 1'b0;
    step();
    reset = 1'b1;
    step();
  endtask

  // Push words first..last, advancing when the selected DUT accepts.
  task automatic push_seq(int sel, logic [31:0] first, logic [31:0] last);
    logic [31:0] w;
    w = first;
    din = w;
    in_vld = 1'b1;
    for (int i = 0; i < 60 && w <= last; i++) begin
      step();
      if (acc_now[sel]) w++;
      din = w;
    end
    in_vld = 1'b0;
  endtask

  initial begin
    // Reset held with ap_start high: ack must stay low.
    reset = 1'b0; start = 1'b1; in_vld = 1'b0; oack = 4'hF;
    repeat (3) step();
    reset = 1'b1;
    step();

    // Round robin with free-running consumers.
    push_seq(0, 32'h10, 32'h17);
    repeat (4) step();

    // Block dealing: 12 words then one more to confirm wrap to output 1.
    do_reset();
    push_seq(1, 32'd0, 32'd12);
    repeat (4) step();

    // Backpressure on output 2, one single ack, then release.
    do_reset();
    oack = 4'b1101;
    din = 32'd0;
    in_vld = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (acc_now[0]) din++;
    end
    oack = 4'hF;
    step();
    if (acc_now[0]) din++;
    oack = 4'b1101;
    for (int i = 0; i < 3; i++) begin
      step();
      if (acc_now[0]) din++;
    end
    oack = 4'hF;
    for (int i = 0; i < 20 && din <= 32'd7; i++) begin
      step();
      if (acc_now[0]) din++;
    end
    in_vld = 1'b0;
    repeat (4) step();

    // ap_start gating mid-block.
    do_reset();
    push_seq(1, 32'd100, 32'd101);
    start = 1'b0;
    in_vld = 1'b1;
    din = 32'd102;
    repeat (4) step();
    start = 1'b1;
    push_seq(1, 32'd102, 32'd106);
    repeat (4) step();

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      reset  = ($urandom_range(0, 199) != 0);
      start  = ($urandom_range(0, 15) != 0);
      in_vld = ($urandom_range(0, 3) != 0);
      din    = $urandom;
      for (int k = 0; k < 4; k++) oack[k] = ($urandom_range(0, 2) != 0);
      step();
    end
    reset = 1'b1;
    in_vld = 1'b0;
    oack = 4'hF;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
